// File: rtl/branch_issue_queue_if.sv
// Dispatch, CDB snoop, flush and issue-stage signals of the branch issue queue.
// The master side drives dispatch/CDB/flush; the slave side is the queue itself.
interface branch_issue_queue_if #(
  parameter int ENTRIES      = 4,
  parameter int WORD_SIZE_P  = 16,
  parameter int WIDTH_OP     = 4,
  parameter int ROB_ENTRY    = 16,
  parameter int NUM_PHYS_REG = 32
);
  localparam int ROB_W  = $clog2(ROB_ENTRY);
  localparam int PREG_W = $clog2(NUM_PHYS_REG);
  localparam int CNT_W  = $clog2(ENTRIES) + 1;

  logic                   disp_v_i;
  logic                   disp_ready_o;
  logic [WIDTH_OP-1:0]    disp_opcode_i;
  logic [WORD_SIZE_P-1:0] disp_pc_i;
  logic [PREG_W-1:0]      disp_src1_tag_i;
  logic [PREG_W-1:0]      disp_src2_tag_i;
  logic                   disp_src1_rdy_i;
  logic                   disp_src2_rdy_i;
  logic [WORD_SIZE_P-1:0] disp_src1_val_i;
  logic [WORD_SIZE_P-1:0] disp_src2_val_i;
  logic [ROB_W-1:0]       disp_rob_dest_i;
  logic [PREG_W-1:0]      disp_reg_dest_i;
  logic                   cdb_v_i;
  logic [PREG_W-1:0]      cdb_dest_i;
  logic [WORD_SIZE_P-1:0] cdb_result_i;
  logic                   flush_i;
  logic                   exe_v_o;
  logic [WIDTH_OP-1:0]    opcode_o;
  logic [WORD_SIZE_P-1:0] pc_o;
  logic [WORD_SIZE_P-1:0] operand1_o;
  logic [WORD_SIZE_P-1:0] operand2_o;
  logic [ROB_W-1:0]       rob_dest_o;
  logic [PREG_W-1:0]      reg_dest_o;
  logic [CNT_W-1:0]       count_o;

  modport master (
    output disp_v_i, disp_opcode_i, disp_pc_i, disp_src1_tag_i, disp_src2_tag_i,
           disp_src1_rdy_i, disp_src2_rdy_i, disp_src1_val_i, disp_src2_val_i,
           disp_rob_dest_i, disp_reg_dest_i, cdb_v_i, cdb_dest_i, cdb_result_i, flush_i,
    input  disp_ready_o, exe_v_o, opcode_o, pc_o, operand1_o, operand2_o,
           rob_dest_o, reg_dest_o, count_o
  );

  modport slave (
    input  disp_v_i, disp_opcode_i, disp_pc_i, disp_src1_tag_i, disp_src2_tag_i,
           disp_src1_rdy_i, disp_src2_rdy_i, disp_src1_val_i, disp_src2_val_i,
           disp_rob_dest_i, disp_reg_dest_i, cdb_v_i, cdb_dest_i, cdb_result_i, flush_i,
    output disp_ready_o, exe_v_o, opcode_o, pc_o, operand1_o, operand2_o,
           rob_dest_o, reg_dest_o, count_o
  );
endinterface

// File: rtl/branch_issue_queue.sv
// In-order issue queue for the branch unit: holds ops until both operands are
// valid (CDB snooping), issues the head through a registered stage, flushes on redirect.
module branch_issue_queue #(
  parameter int ENTRIES      = 4,
  parameter int WORD_SIZE_P  = 16,
  parameter int WIDTH_OP     = 4,
  parameter int ROB_ENTRY    = 16,
  parameter int NUM_PHYS_REG = 32
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  branch_issue_queue_if.slave bus
);
  localparam int PTR_W  = $clog2(ENTRIES);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ROB_W  = $clog2(ROB_ENTRY);
  localparam int PREG_W = $clog2(NUM_PHYS_REG);

  typedef struct packed {
    logic                   valid;
    logic [WIDTH_OP-1:0]    opcode;
    logic [WORD_SIZE_P-1:0] pc;
    logic [PREG_W-1:0]      src1_tag;
    logic                   src1_rdy;
    logic [WORD_SIZE_P-1:0] src1_val;
    logic [PREG_W-1:0]      src2_tag;
    logic                   src2_rdy;
    logic [WORD_SIZE_P-1:0] src2_val;
    logic [ROB_W-1:0]       rob_dest;
    logic [PREG_W-1:0]      reg_dest;
  } entry_t;

  entry_t             q [ENTRIES];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic                   exe_v;
  logic [WIDTH_OP-1:0]    iss_opcode;
  logic [WORD_SIZE_P-1:0] iss_pc, iss_op1, iss_op2;
  logic [ROB_W-1:0]       iss_rob;
  logic [PREG_W-1:0]      iss_reg;

  entry_t head_e, new_e;
  logic   disp_ready, do_disp, do_issue, wake1, wake2;

  assign disp_ready = (count != CNT_W'(ENTRIES));
  assign do_disp    = bus.disp_v_i && disp_ready && !bus.flush_i;
  assign head_e     = q[head];
  // Readiness uses stored bits only; a CDB hit this cycle lets the head issue next cycle.
  assign do_issue   = head_e.valid && head_e.src1_rdy && head_e.src2_rdy && !bus.flush_i;
  assign wake1      = bus.cdb_v_i && (bus.cdb_dest_i == bus.disp_src1_tag_i);
  assign wake2      = bus.cdb_v_i && (bus.cdb_dest_i == bus.disp_src2_tag_i);

  // NOTE: every field of new_e is assigned before use, so no latch can be inferred.
  always_comb begin
    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.opcode   = bus.disp_opcode_i;
    new_e.pc       = bus.disp_pc_i;
    new_e.src1_tag = bus.disp_src1_tag_i;
    new_e.src2_tag = bus.disp_src2_tag_i;
    new_e.src1_rdy = bus.disp_src1_rdy_i || wake1;
    new_e.src2_rdy = bus.disp_src2_rdy_i || wake2;
    new_e.src1_val = bus.disp_src1_rdy_i ? bus.disp_src1_val_i : bus.cdb_result_i;
    new_e.src2_val = bus.disp_src2_rdy_i ? bus.disp_src2_val_i : bus.cdb_result_i;
    new_e.rob_dest = bus.disp_rob_dest_i;
    new_e.reg_dest = bus.disp_reg_dest_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: whole entries are cleared on reset so no X ever reaches the issue registers.
      for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      exe_v      <= 1'b0;
      iss_opcode <= '0;
      iss_pc     <= '0;
      iss_op1    <= '0;
      iss_op2    <= '0;
      iss_rob    <= '0;
      iss_reg    <= '0;
    end else if (bus.flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        q[i].valid    <= 1'b0;
        q[i].src1_rdy <= 1'b0;
        q[i].src2_rdy <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
      exe_v <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (q[i].valid && !q[i].src1_rdy && bus.cdb_v_i && q[i].src1_tag == bus.cdb_dest_i) begin
          q[i].src1_rdy <= 1'b1;
          q[i].src1_val <= bus.cdb_result_i;
        end
        if (q[i].valid && !q[i].src2_rdy && bus.cdb_v_i && q[i].src2_tag == bus.cdb_dest_i) begin
          q[i].src2_rdy <= 1'b1;
          q[i].src2_val <= bus.cdb_result_i;
        end
      end

      exe_v <= do_issue;
      if (do_issue) begin
        q[head].valid <= 1'b0;
        head          <= head + 1'b1;
        iss_opcode    <= head_e.opcode;
        iss_pc        <= head_e.pc;
        iss_op1       <= head_e.src1_val;
        iss_op2       <= head_e.src2_val;
        iss_rob       <= head_e.rob_dest;
        iss_reg       <= head_e.reg_dest;
      end

      if (do_disp) begin
        q[tail] <= new_e;
        tail    <= tail + 1'b1;
      end

      case ({do_disp, do_issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.disp_ready_o = disp_ready;
  assign bus.exe_v_o      = exe_v;
  assign bus.opcode_o     = iss_opcode;
  assign bus.pc_o         = iss_pc;
  assign bus.operand1_o   = iss_op1;
  assign bus.operand2_o   = iss_op2;
  assign bus.rob_dest_o   = iss_rob;
  assign bus.reg_dest_o   = iss_reg;
  assign bus.count_o      = count;
endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue: latency, CDB wakeup, full queue,
// dispatch-cycle wakeup, flush and asynchronous reset.
module tb_branch_issue_queue;
  localparam logic [3:0] OP_BL  = 4'h1;
  localparam logic [3:0] OP_BCC = 4'h2;

  logic clk_i = 1'b0;
  logic reset_n_i;
  int   tests  = 0;
  int   failed = 0;

  branch_issue_queue_if #(.ENTRIES(4), .WORD_SIZE_P(16), .WIDTH_OP(4),
                          .ROB_ENTRY(16), .NUM_PHYS_REG(32)) bus ();

  branch_issue_queue #(.ENTRIES(4), .WORD_SIZE_P(16), .WIDTH_OP(4),
                       .ROB_ENTRY(16), .NUM_PHYS_REG(32)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  // Advance past the next rising edge; outputs are sampled and inputs changed here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.disp_v_i        = 1'b0;
    bus.disp_opcode_i   = '0;
    bus.disp_pc_i       = '0;
    bus.disp_src1_tag_i = '0;
    bus.disp_src2_tag_i = '0;
    bus.disp_src1_rdy_i = 1'b0;
    bus.disp_src2_rdy_i = 1'b0;
    bus.disp_src1_val_i = '0;
    bus.disp_src2_val_i = '0;
    bus.disp_rob_dest_i = '0;
    bus.disp_reg_dest_i = '0;
    bus.cdb_v_i         = 1'b0;
    bus.cdb_dest_i      = '0;
    bus.cdb_result_i    = '0;
    bus.flush_i         = 1'b0;
  endtask

  task automatic drive_disp(input logic [3:0] op, input logic [15:0] pc,
                            input logic [4:0] t1, input logic r1, input logic [15:0] v1,
                            input logic [4:0] t2, input logic r2, input logic [15:0] v2,
                            input logic [3:0] rob, input logic [4:0] rd);
    bus.disp_v_i        = 1'b1;
    bus.disp_opcode_i   = op;
    bus.disp_pc_i       = pc;
    bus.disp_src1_tag_i = t1;
    bus.disp_src1_rdy_i = r1;
    bus.disp_src1_val_i = v1;
    bus.disp_src2_tag_i = t2;
    bus.disp_src2_rdy_i = r2;
    bus.disp_src2_val_i = v2;
    bus.disp_rob_dest_i = rob;
    bus.disp_reg_dest_i = rd;
  endtask

  task automatic drive_cdb(input logic [4:0] dest, input logic [15:0] res);
    bus.cdb_v_i      = 1'b1;
    bus.cdb_dest_i   = dest;
    bus.cdb_result_i = res;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n_i = 1'b0;
    tick();
    tick();
    tests++; if (bus.exe_v_o !== 1'b0) begin failed++; $display("FAIL reset_exe_v: got %b want 0", bus.exe_v_o); end
    tests++; if (bus.count_o !== 3'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    tests++; if (bus.pc_o !== 16'h0 || bus.operand1_o !== 16'h0 || bus.rob_dest_o !== 4'd0)
      begin failed++; $display("FAIL reset_issue_regs: pc=%h op1=%h rob=%0d want all 0", bus.pc_o, bus.operand1_o, bus.rob_dest_o); end
    reset_n_i = 1'b1;
    tick();
    tests++; if (bus.disp_ready_o !== 1'b1) begin failed++; $display("FAIL reset_disp_ready: got %b want 1", bus.disp_ready_o); end
  endtask

  task automatic test_ready_dispatch();
    drive_disp(OP_BL, 16'h0010, 5'd1, 1'b1, 16'h0AAA, 5'd2, 1'b1, 16'h0BBB, 4'd3, 5'd7);
    tick();
    clear_inputs();
    tests++; if (bus.exe_v_o !== 1'b0) begin failed++; $display("FAIL ready_early_exe_v: got %b want 0", bus.exe_v_o); end
    tests++; if (bus.count_o !== 3'd1) begin failed++; $display("FAIL ready_count_1: got %0d want 1", bus.count_o); end
    tick();
    tests++; if (bus.exe_v_o !== 1'b1) begin failed++; $display("FAIL ready_exe_v: got %b want 1", bus.exe_v_o); end
    tests++; if (bus.pc_o !== 16'h0010) begin failed++; $display("FAIL ready_pc: got %h want 0010", bus.pc_o); end
    tests++; if (bus.rob_dest_o !== 4'd3 || bus.reg_dest_o !== 5'd7)
      begin failed++; $display("FAIL ready_dest: rob=%0d reg=%0d want 3 7", bus.rob_dest_o, bus.reg_dest_o); end
    tests++; if (bus.opcode_o !== OP_BL || bus.operand1_o !== 16'h0AAA || bus.operand2_o !== 16'h0BBB)
      begin failed++; $display("FAIL ready_fields: op=%h o1=%h o2=%h want 1 0aaa 0bbb", bus.opcode_o, bus.operand1_o, bus.operand2_o); end
    tests++; if (bus.count_o !== 3'd0) begin failed++; $display("FAIL ready_count_0: got %0d want 0", bus.count_o); end
    tick();
    tests++; if (bus.exe_v_o !== 1'b0) begin failed++; $display("FAIL ready_exe_v_drop: got %b want 0", bus.exe_v_o); end
  endtask

  task automatic test_cdb_wakeup();
    // src1 is already ready with the same tag; the later CDB hit must not overwrite it.
    drive_disp(OP_BCC, 16'h0020, 5'd5, 1'b1, 16'h0011, 5'd5, 1'b0, 16'hDEAD, 4'd4, 5'd8);
    tick();
    clear_inputs();
    tick();
    tick();
    tests++; if (bus.exe_v_o !== 1'b0 || bus.count_o !== 3'd1)
      begin failed++; $display("FAIL cdb_wait: exe_v=%b count=%0d want 0 1", bus.exe_v_o, bus.count_o); end
    drive_cdb(5'd5, 16'h0004);
    tick();
    clear_inputs();
    tests++; if (bus.exe_v_o !== 1'b0) begin failed++; $display("FAIL cdb_no_bypass: got %b want 0", bus.exe_v_o); end
    tick();
    tests++; if (bus.exe_v_o !== 1'b1) begin failed++; $display("FAIL cdb_exe_v: got %b want 1", bus.exe_v_o); end
    tests++; if (bus.operand2_o !== 16'h0004) begin failed++; $display("FAIL cdb_operand2: got %h want 0004", bus.operand2_o); end
    tests++; if (bus.operand1_o !== 16'h0011) begin failed++; $display("FAIL cdb_keep_operand1: got %h want 0011", bus.operand1_o); end
    tests++; if (bus.pc_o !== 16'h0020 || bus.opcode_o !== OP_BCC)
      begin failed++; $display("FAIL cdb_pc: pc=%h op=%h want 0020 2", bus.pc_o, bus.opcode_o); end
    tick();
  endtask

  task automatic test_full_in_order();
    logic [15:0] pcs [4];
    pcs[0] = 16'h00A0; pcs[1] = 16'h00B0; pcs[2] = 16'h00C0; pcs[3] = 16'h00D0;
    drive_disp(OP_BCC, pcs[0], 5'd3, 1'b0, 16'h0, 5'd0, 1'b1, 16'h0001, 4'd0, 5'd10);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive_disp(OP_BL, pcs[i], 5'd0, 1'b1, 16'h0, 5'd0, 1'b1, 16'h0, 4'(i), 5'(10 + i));
      tick();
    end
    clear_inputs();
    tests++; if (bus.count_o !== 3'd4) begin failed++; $display("FAIL full_count: got %0d want 4", bus.count_o); end
    tests++; if (bus.disp_ready_o !== 1'b0) begin failed++; $display("FAIL full_disp_ready: got %b want 0", bus.disp_ready_o); end
    drive_disp(OP_BL, 16'h00E0, 5'd0, 1'b1, 16'h0, 5'd0, 1'b1, 16'h0, 4'd9, 5'd20);
    tick();
    clear_inputs();
    tests++; if (bus.count_o !== 3'd4 || bus.exe_v_o !== 1'b0)
      begin failed++; $display("FAIL full_ignore_extra: count=%0d exe_v=%b want 4 0", bus.count_o, bus.exe_v_o); end
    drive_cdb(5'd3, 16'h0033);
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (bus.exe_v_o !== 1'b1 || bus.pc_o !== pcs[i])
        begin failed++; $display("FAIL full_order_%0d: exe_v=%b pc=%h want 1 %h", i, bus.exe_v_o, bus.pc_o, pcs[i]); end
    end
    tests++; if (bus.count_o !== 3'd0) begin failed++; $display("FAIL full_drain_count: got %0d want 0", bus.count_o); end
    tick();
    tests++; if (bus.exe_v_o !== 1'b0) begin failed++; $display("FAIL full_no_extra_issue: got %b want 0", bus.exe_v_o); end
  endtask

  task automatic test_dispatch_wakeup();
    drive_disp(OP_BCC, 16'h0040, 5'd9, 1'b0, 16'hBEEF, 5'd1, 1'b1, 16'h0002, 4'd6, 5'd12);
    drive_cdb(5'd9, 16'h1234);
    tick();
    clear_inputs();
    tick();
    tests++; if (bus.exe_v_o !== 1'b1 || bus.pc_o !== 16'h0040)
      begin failed++; $display("FAIL dwake_issue: exe_v=%b pc=%h want 1 0040", bus.exe_v_o, bus.pc_o); end
    tests++; if (bus.operand1_o !== 16'h1234 || bus.operand2_o !== 16'h0002)
      begin failed++; $display("FAIL dwake_operands: o1=%h o2=%h want 1234 0002", bus.operand1_o, bus.operand2_o); end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_disp(OP_BCC, 16'(16'h0050 + i), 5'd6, 1'b0, 16'h0, 5'd0, 1'b1, 16'h0, 4'(i), 5'd1);
      tick();
    end
    clear_inputs();
    tests++; if (bus.count_o !== 3'd3) begin failed++; $display("FAIL flush_pre_count: got %0d want 3", bus.count_o); end
    drive_disp(OP_BL, 16'h00F0, 5'd0, 1'b1, 16'h0, 5'd0, 1'b1, 16'h0, 4'd7, 5'd2);
    bus.flush_i = 1'b1;
    tick();
    clear_inputs();
    tests++; if (bus.count_o !== 3'd0 || bus.exe_v_o !== 1'b0 || bus.disp_ready_o !== 1'b1)
      begin failed++; $display("FAIL flush_clear: count=%0d exe_v=%b ready=%b want 0 0 1", bus.count_o, bus.exe_v_o, bus.disp_ready_o); end
    drive_cdb(5'd6, 16'h0666);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.exe_v_o !== 1'b0) begin failed++; $display("FAIL flush_stale_issue_%0d: got %b want 0", i, bus.exe_v_o); end
    end
    // A ready head must not issue on the flush edge.
    drive_disp(OP_BL, 16'h0200, 5'd0, 1'b1, 16'h0, 5'd0, 1'b1, 16'h0, 4'd1, 5'd3);
    tick();
    clear_inputs();
    bus.flush_i = 1'b1;
    tick();
    clear_inputs();
    tests++; if (bus.exe_v_o !== 1'b0 || bus.count_o !== 3'd0)
      begin failed++; $display("FAIL flush_suppress_issue: exe_v=%b count=%0d want 0 0", bus.exe_v_o, bus.count_o); end
    drive_disp(OP_BL, 16'h0300, 5'd0, 1'b1, 16'h0, 5'd0, 1'b1, 16'h0, 4'd2, 5'd4);
    tick();
    clear_inputs();
    tick();
    tests++; if (bus.exe_v_o !== 1'b1 || bus.pc_o !== 16'h0300)
      begin failed++; $display("FAIL flush_recover: exe_v=%b pc=%h want 1 0300", bus.exe_v_o, bus.pc_o); end
    tick();
  endtask

  task automatic test_async_reset();
    drive_disp(OP_BL, 16'h0400, 5'd0, 1'b1, 16'h0, 5'd0, 1'b1, 16'h0, 4'd5, 5'd5);
    tick();
    drive_disp(OP_BCC, 16'h0410, 5'd10, 1'b0, 16'h0, 5'd0, 1'b1, 16'h0, 4'd6, 5'd6);
    tick();
    clear_inputs();
    tests++; if (bus.exe_v_o !== 1'b1 || bus.count_o !== 3'd1)
      begin failed++; $display("FAIL areset_pre: exe_v=%b count=%0d want 1 1", bus.exe_v_o, bus.count_o); end
    #2;
    reset_n_i = 1'b0;
    #1;
    tests++; if (bus.exe_v_o !== 1'b0 || bus.count_o !== 3'd0)
      begin failed++; $display("FAIL areset_clear: exe_v=%b count=%0d want 0 0", bus.exe_v_o, bus.count_o); end
    tests++; if (bus.pc_o !== 16'h0 || bus.reg_dest_o !== 5'd0)
      begin failed++; $display("FAIL areset_issue_regs: pc=%h reg=%0d want 0 0", bus.pc_o, bus.reg_dest_o); end
    tick();
    reset_n_i = 1'b1;
    drive_cdb(5'd10, 16'h0010);
    tick();
    clear_inputs();
    tick();
    tests++; if (bus.exe_v_o !== 1'b0 || bus.disp_ready_o !== 1'b1)
      begin failed++; $display("FAIL areset_after: exe_v=%b ready=%b want 0 1", bus.exe_v_o, bus.disp_ready_o); end
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_full_in_order();
    test_dispatch_wakeup();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
